// File: rtl/pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// pll_reset_sequencer
//
// Purpose:
//   Sits between the PLL wrapper and the SoC top. It drives the PLL reset,
//   watches the PLL locked flag and releases the system resets in stages:
//   first sys_rst (core/bus), then periph_rst (peripherals). It runs on the
//   free-running board reference clock, so it keeps working while the PLL is
//   unlocked. The reset outputs are synchronous to clk. Each PLL output domain
//   re-synchronizes them locally.
//
//   Sequence: PLL_RST -> WAIT_LOCK -> SYS_REL -> RUN
//     PLL_RST   : pll_rst held high for PLL_RST_CYCLES.
//     WAIT_LOCK : waits for LOCK_STABLE_CYCLES consecutive clean lock cycles.
//                 After LOCK_TIMEOUT_CYCLES it starts a new PLL reset attempt
//                 and sets the sticky lock_timeout flag.
//     SYS_REL   : sys_rst released. periph_rst follows after STAGE_CYCLES.
//     RUN       : everything released, ready=1.
//   A lock loss in SYS_REL/RUN restarts from PLL_RST and counts the drop.
//   An external reset request in SYS_REL/RUN goes back to WAIT_LOCK and
//   leaves the PLL running.
//
// Ports:
//   clk              in   board reference clock
//   rst              in   asynchronous active-high reset
//   pll_locked       in   PLL locked flag, asynchronous to clk
//   ext_reset_req    in   external reset request, asynchronous, active-high
//   pll_rst          out  to PLL rst input
//   sys_rst          out  core/bus reset, active-high
//   periph_rst       out  peripheral reset, active-high
//   ready            out  high only in RUN
//   lock_timeout     out  sticky WAIT_LOCK timeout flag, cleared only by rst
//   lock_loss_count  out  saturating count of lock drops in SYS_REL/RUN
//   state_dbg        out  current FSM state (0 PLL_RST, 1 WAIT_LOCK,
//                         2 SYS_REL, 3 RUN)
// -----------------------------------------------------------------------------
module pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int STAGE_CYCLES        = 16,
  parameter int SYNC_STAGES         = 2,
  parameter int CNT_W               = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pll_locked,
  input  logic             ext_reset_req,
  output logic             pll_rst,
  output logic             sys_rst,
  output logic             periph_rst,
  output logic             ready,
  output logic             lock_timeout,
  output logic [CNT_W-1:0] lock_loss_count,
  output logic [1:0]       state_dbg
);

  // The largest terminal count sets the width of both counters. The extra
  // bit guarantees that no counter wraps before its compare matches.
  localparam int MAX_A  = (PLL_RST_CYCLES > STAGE_CYCLES) ? PLL_RST_CYCLES : STAGE_CYCLES;
  localparam int MAX_B  = (LOCK_STABLE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                          LOCK_STABLE_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int MAX_P  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW     = $clog2(MAX_P) + 1;

  localparam logic [CW-1:0] PLL_RST_LAST = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] STAGE_LAST   = CW'(STAGE_CYCLES - 1);
  localparam logic [CNT_W-1:0] COUNT_MAX = '1;

  typedef enum logic [1:0] {
    S_PLL_RST   = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_SYS_REL   = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic [SYNC_STAGES-1:0] locked_sync;
  logic [SYNC_STAGES-1:0] ext_sync;
  logic                   locked_s;
  logic                   ext_s;

  logic [CW-1:0] cnt;
  logic [CW-1:0] stab;

  logic set_timeout;
  logic lock_lost;

  logic pll_rst_next;
  logic sys_rst_next;
  logic periph_rst_next;
  logic ready_next;

  // ---------------------------------------------------------------------------
  // Input synchronizers. Both asynchronous inputs pass through SYNC_STAGES
  // flops, and only the last stage feeds the FSM.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      locked_sync <= '0;
      ext_sync    <= '0;
    end else begin
      locked_sync <= {locked_sync[SYNC_STAGES-2:0], pll_locked};
      ext_sync    <= {ext_sync[SYNC_STAGES-2:0], ext_reset_req};
    end
  end

  assign locked_s = locked_sync[SYNC_STAGES-1];
  assign ext_s    = ext_sync[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_PLL_RST;
    end else begin
      state <= state_next;
    end
  end

  assign state_dbg = state;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next  = state;
    set_timeout = 1'b0;
    lock_lost   = 1'b0;
    case (state)
      S_PLL_RST: begin
        // ext_s is deliberately ignored here.
        if (cnt == PLL_RST_LAST) state_next = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        // The stable-lock release wins over a timeout in the same cycle.
        if (stab == STABLE_LAST && locked_s) begin
          state_next = S_SYS_REL;
        end else if (cnt == TIMEOUT_LAST) begin
          state_next  = S_PLL_RST;
          set_timeout = 1'b1;
        end
      end
      S_SYS_REL: begin
        // Priority order: lock loss, then external request, then stage done.
        if (!locked_s) begin
          state_next = S_PLL_RST;
          lock_lost  = 1'b1;
        end else if (ext_s) begin
          state_next = S_WAIT_LOCK;
        end else if (cnt == STAGE_LAST) begin
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (!locked_s) begin
          state_next = S_PLL_RST;
          lock_lost  = 1'b1;
        end else if (ext_s) begin
          state_next = S_WAIT_LOCK;
        end
      end
      default: state_next = S_PLL_RST;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Counters and status.
  // cnt restarts on every state change. It is held at 0 in RUN, where
  // nothing compares it, so it cannot free-run and wrap.
  // stab counts only clean lock cycles (locked, no external request) while
  // the FSM stays in WAIT_LOCK. Any other cycle clears it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt             <= '0;
      stab            <= '0;
      lock_timeout    <= 1'b0;
      lock_loss_count <= '0;
    end else begin
      if (state_next != state || state_next == S_RUN) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end

      if (state == S_WAIT_LOCK && state_next == S_WAIT_LOCK && locked_s && !ext_s) begin
        stab <= stab + 1'b1;
      end else begin
        stab <= '0;
      end

      if (set_timeout) lock_timeout <= 1'b1;

      if (lock_lost && lock_loss_count != COUNT_MAX) begin
        lock_loss_count <= lock_loss_count + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode. The decode uses the next state, so the registered
  // outputs always match the state register after each edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    pll_rst_next    = 1'b1;
    sys_rst_next    = 1'b1;
    periph_rst_next = 1'b1;
    ready_next      = 1'b0;
    case (state_next)
      S_PLL_RST: begin
        pll_rst_next    = 1'b1;
        sys_rst_next    = 1'b1;
        periph_rst_next = 1'b1;
      end
      S_WAIT_LOCK: begin
        pll_rst_next    = 1'b0;
        sys_rst_next    = 1'b1;
        periph_rst_next = 1'b1;
      end
      S_SYS_REL: begin
        pll_rst_next    = 1'b0;
        sys_rst_next    = 1'b0;
        periph_rst_next = 1'b1;
      end
      S_RUN: begin
        pll_rst_next    = 1'b0;
        sys_rst_next    = 1'b0;
        periph_rst_next = 1'b0;
        ready_next      = 1'b1;
      end
      default: begin
        pll_rst_next    = 1'b1;
        sys_rst_next    = 1'b1;
        periph_rst_next = 1'b1;
        ready_next      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pll_rst    <= 1'b1;
      sys_rst    <= 1'b1;
      periph_rst <= 1'b1;
      ready      <= 1'b0;
    end else begin
      pll_rst    <= pll_rst_next;
      sys_rst    <= sys_rst_next;
      periph_rst <= periph_rst_next;
      ready      <= ready_next;
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pll_reset_sequencer
//
// Directed bench for pll_reset_sequencer. It uses small terminal counts:
// LOCK_STABLE=8, LOCK_TIMEOUT=64, PLL_RST=4, STAGE=4 and SYNC_STAGES=2.
//
// Inputs are driven #1 after a rising edge and outputs are sampled at the
// same point. A change applied after edge E reaches the FSM's synchronized
// view after edge E+2, and the FSM acts on it at edge E+3.
// -----------------------------------------------------------------------------
module tb_pll_reset_sequencer;

  localparam int CNT_W = 8;

  logic             clk;
  logic             rst;
  logic             pll_locked;
  logic             ext_reset_req;
  logic             pll_rst;
  logic             sys_rst;
  logic             periph_rst;
  logic             ready;
  logic             lock_timeout;
  logic [CNT_W-1:0] lock_loss_count;
  logic [1:0]       state_dbg;

  int checks   = 0;
  int failures = 0;

  localparam logic [1:0] ST_PLL_RST   = 2'd0;
  localparam logic [1:0] ST_WAIT_LOCK = 2'd1;
  localparam logic [1:0] ST_RUN       = 2'd3;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES      (4),
    .LOCK_STABLE_CYCLES  (8),
    .LOCK_TIMEOUT_CYCLES (64),
    .STAGE_CYCLES        (4),
    .SYNC_STAGES         (2),
    .CNT_W               (CNT_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .pll_locked      (pll_locked),
    .ext_reset_req   (ext_reset_req),
    .pll_rst         (pll_rst),
    .sys_rst         (sys_rst),
    .periph_rst      (periph_rst),
    .ready           (ready),
    .lock_timeout    (lock_timeout),
    .lock_loss_count (lock_loss_count),
    .state_dbg       (state_dbg)
  );

  // Clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: the run must always terminate on its own.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running required finished");
    $fatal(1, "watchdog expired");
  end

  // Checking task
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Driver helpers
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for sys_rst release, then applies a 1-cycle lock drop
  // and checks the PLL reset and the saturating drop count.
  task automatic do_drop(input int exp_count);
    int waited;
    waited = 0;
    while (sys_rst !== 1'b0 && waited < 200) begin
      wait_cycles(1);
      waited++;
    end
    check("drop_reach_sysrel", sys_rst, 0);
    pll_locked = 1'b0;
    wait_cycles(1);
    pll_locked = 1'b1;
    wait_cycles(2);
    check("drop_pll_rst", pll_rst, 1);
    check("drop_count", lock_loss_count, exp_count);
  endtask

  logic sys_low_seen;

  initial begin
    rst           = 1'b1;
    pll_locked    = 1'b0;
    ext_reset_req = 1'b0;
    wait_cycles(3);

    // Reset state
    check("rst_pll_rst", pll_rst, 1);
    check("rst_sys_rst", sys_rst, 1);
    check("rst_periph_rst", periph_rst, 1);
    check("rst_ready", ready, 0);
    check("rst_lock_timeout", lock_timeout, 0);
    check("rst_count", lock_loss_count, 0);

    // 1: Power-up. Edges are numbered from the rst release.
    rst = 1'b0;
    wait_cycles(3);                          // edge 3
    check("pwr_pll_rst_held", pll_rst, 1);
    wait_cycles(1);                          // edge 4
    check("pwr_pll_rst_low", pll_rst, 0);
    check("pwr_state_wait", state_dbg, ST_WAIT_LOCK);
    wait_cycles(1);                          // edge 5
    pll_locked = 1'b1;                       // locked_s rises after edge 7
    wait_cycles(9);                          // edge 14
    check("pwr_sys_rst_held", sys_rst, 1);
    wait_cycles(1);                          // edge 15
    check("pwr_sys_rst_rel", sys_rst, 0);
    check("pwr_periph_held", periph_rst, 1);
    wait_cycles(3);                          // edge 18
    check("pwr_ready_low", ready, 0);
    wait_cycles(1);                          // edge 19
    check("pwr_periph_rel", periph_rst, 0);
    check("pwr_ready", ready, 1);
    check("pwr_state_run", state_dbg, ST_RUN);
    check("pwr_lock_timeout", lock_timeout, 0);
    check("pwr_count", lock_loss_count, 0);

    // 3: Lock loss in RUN. This is a 1-cycle drop applied after edge A.
    pll_locked = 1'b0;
    wait_cycles(1);
    pll_locked = 1'b1;
    wait_cycles(1);                          // A+2
    check("loss_ready_still", ready, 1);
    wait_cycles(1);                          // A+3
    check("loss_pll_rst", pll_rst, 1);
    check("loss_sys_rst", sys_rst, 1);
    check("loss_periph_rst", periph_rst, 1);
    check("loss_ready", ready, 0);
    check("loss_count", lock_loss_count, 1);
    wait_cycles(15);                         // A+18
    check("loss_reseq_ready_low", ready, 0);
    wait_cycles(1);                          // A+19
    check("loss_reseq_ready", ready, 1);
    check("loss_reseq_sys_rst", sys_rst, 0);

    // 4: ext_reset_req held for 20 cycles in RUN, starting after edge B.
    ext_reset_req = 1'b1;
    wait_cycles(3);                          // B+3
    check("ext_sys_rst", sys_rst, 1);
    check("ext_periph_rst", periph_rst, 1);
    check("ext_pll_rst_low", pll_rst, 0);
    check("ext_ready", ready, 0);
    wait_cycles(17);                         // B+20
    check("ext_pll_rst_still_low", pll_rst, 0);
    ext_reset_req = 1'b0;                    // ext_s falls after B+22
    wait_cycles(9);                          // B+29
    check("ext_sys_rst_held", sys_rst, 1);
    wait_cycles(1);                          // B+30
    check("ext_sys_rst_rel", sys_rst, 0);
    check("ext_count", lock_loss_count, 1);
    wait_cycles(4);                          // B+34
    check("ext_ready_back", ready, 1);

    // 5: ext request and lock drop in the same cycle, after edge C.
    ext_reset_req = 1'b1;
    pll_locked    = 1'b0;
    wait_cycles(3);                          // C+3
    check("both_pll_rst", pll_rst, 1);
    check("both_state", state_dbg, ST_PLL_RST);
    check("both_count", lock_loss_count, 2);
    ext_reset_req = 1'b0;
    pll_locked    = 1'b1;
    wait_cycles(16);                         // C+19
    check("both_ready_back", ready, 1);

    // 2: Glitchy lock after a fresh reset. The lock is low 1 cycle in 5,
    //    so the stable count never reaches 8 and WAIT_LOCK times out at
    //    edge 68.
    rst = 1'b1;
    #1;
    check("rst2_count_cleared", lock_loss_count, 0);
    check("rst2_pll_rst", pll_rst, 1);
    wait_cycles(2);
    rst = 1'b0;
    sys_low_seen = 1'b0;
    for (int i = 0; i < 72; i++) begin
      pll_locked = (i % 5 != 4);
      wait_cycles(1);                        // edge i+1
      if (sys_rst == 1'b0) sys_low_seen = 1'b1;
      if (i + 1 == 67) begin
        check("glitch_no_timeout_yet", lock_timeout, 0);
        check("glitch_pll_rst_low", pll_rst, 0);
      end
      if (i + 1 == 68) begin
        check("glitch_timeout", lock_timeout, 1);
        check("glitch_pll_rst_pulse", pll_rst, 1);
      end
      if (i + 1 == 71) check("glitch_pll_rst_held", pll_rst, 1);
      if (i + 1 == 72) check("glitch_pll_rst_end", pll_rst, 0);
    end
    check("glitch_sys_rst_stayed", sys_low_seen, 0);

    // 6: Saturation of lock_loss_count after 257 drops, then rst in
    //    WAIT_LOCK.
    pll_locked = 1'b1;
    for (int i = 0; i < 257; i++) begin
      do_drop((i < 255) ? i + 1 : 255);
    end
    wait_cycles(5);                          // inside WAIT_LOCK
    check("sat_in_wait_lock", state_dbg, ST_WAIT_LOCK);
    check("sat_timeout_sticky", lock_timeout, 1);
    rst = 1'b1;
    #1;
    check("midrst_pll_rst", pll_rst, 1);
    check("midrst_sys_rst", sys_rst, 1);
    check("midrst_periph_rst", periph_rst, 1);
    check("midrst_ready", ready, 0);
    check("midrst_timeout", lock_timeout, 0);
    check("midrst_count", lock_loss_count, 0);
    check("midrst_state", state_dbg, ST_PLL_RST);
    wait_cycles(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
